// File: rtl/fetch_pkg.sv
// Shared constants for the fetch queue: default depth, pointer width helper and
// the instruction value presented to decode when no instruction is valid.
package fetch_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int PTR_W     = $clog2(DEF_DEPTH) + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Pointers carry one extra MSB so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: pc register link, instruction memory port and IF/ID handshake.
interface fetch_queue_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] pc_in;
  logic              stall_pc;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  modport master (
    input  pc_in, flush, imem_ready, imem_rvalid, imem_rdata, id_ready,
    output stall_pc, imem_req, imem_addr, id_valid, id_instr, id_pc
  );
  modport slave (
    output pc_in, flush, imem_ready, imem_rvalid, imem_rdata, id_ready,
    input  stall_pc, imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/fq_slot_buf.sv
// Slot storage for the fetch queue: alloc port writes the PC, fill port writes the
// instruction, one read port for the head. Only the filled bits are reset.
module fq_slot_buf #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en_i,
  input  logic [IDX_W-1:0]  alloc_idx_i,
  input  logic [ADDR_W-1:0] alloc_pc_i,
  input  logic              fill_en_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_pc_o,
  output logic [DATA_W-1:0] rd_instr_o,
  output logic              rd_filled_o
);
  logic [DEPTH-1:0][ADDR_W-1:0] pc_q;
  logic [DEPTH-1:0][DATA_W-1:0] instr_q;
  logic [DEPTH-1:0]             filled_q;

  // Alloc and fill never target the same slot: fill hits an allocated slot, alloc a free one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filled_q <= '0;
    end else begin
      if (alloc_en_i) filled_q[alloc_idx_i] <= 1'b0;
      if (fill_en_i)  filled_q[fill_idx_i]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en_i) pc_q[alloc_idx_i]   <= alloc_pc_i;
    if (fill_en_i)  instr_q[fill_idx_i] <= fill_data_i;
  end

  assign rd_pc_o     = pc_q[rd_idx_i];
  assign rd_instr_o  = instr_q[rd_idx_i];
  assign rd_filled_o = filled_q[rd_idx_i];
endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the pc register and IF/ID; tracks
// outstanding memory requests and drops wrong-path responses after a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam int SW = PW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [PW-1:0]     alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
  logic [PW-1:0]     discard_q, discard_d;
  logic [PW-1:0]     alloc_cnt, inflight;
  logic [SW-1:0]     pend;
  logic              can_issue, fire, pop, rsp_drop, rsp_fill, head_filled;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;

  assign alloc_cnt = alloc_q - rd_q;
  assign inflight  = alloc_q - fill_q;
  // Responses still owed by memory: wrong-path ones plus live ones.
  assign pend      = {1'b0, discard_q} + {1'b0, inflight};
  assign can_issue = (alloc_cnt < DEPTH_P) & (pend < DEPTH_S);

  assign bus.imem_req  = rst & can_issue & ~bus.flush;
  assign bus.imem_addr = bus.pc_in;
  assign fire          = bus.imem_req & bus.imem_ready;
  assign bus.stall_pc  = ~rst | ~(fire | bus.flush);

  assign bus.id_valid  = (alloc_cnt != '0) & head_filled;
  assign bus.id_instr  = bus.id_valid ? head_instr : DATA_W'(NOP_INSTR);
  assign bus.id_pc     = head_pc;

  assign pop      = bus.id_valid & bus.id_ready & ~bus.flush;
  assign rsp_drop = bus.imem_rvalid & (discard_q != '0);
  assign rsp_fill = bus.imem_rvalid & (discard_q == '0) & (inflight != '0) & ~bus.flush;

  always_comb begin
    alloc_d   = alloc_q;
    fill_d    = fill_q;
    rd_d      = rd_q;
    discard_d = discard_q;
    if (bus.flush) begin
      // Everything in flight becomes wrong-path; a response this cycle is already one of them.
      alloc_d   = '0;
      fill_d    = '0;
      rd_d      = '0;
      discard_d = discard_q + inflight - PW'(bus.imem_rvalid && (pend != '0));
    end else begin
      if (fire)     alloc_d   = alloc_q + PW'(1);
      if (rsp_fill) fill_d    = fill_q + PW'(1);
      if (rsp_drop) discard_d = discard_q - PW'(1);
      if (pop)      rd_d      = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q   <= '0;
      fill_q    <= '0;
      rd_q      <= '0;
      discard_q <= '0;
    end else begin
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      rd_q      <= rd_d;
      discard_q <= discard_d;
    end
  end

  fq_slot_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slots (
    .clk         (clk),
    .rst         (rst),
    .alloc_en_i  (fire),
    .alloc_idx_i (alloc_q[IW-1:0]),
    .alloc_pc_i  (bus.pc_in),
    .fill_en_i   (rsp_fill),
    .fill_idx_i  (fill_q[IW-1:0]),
    .fill_data_i (bus.imem_rdata),
    .rd_idx_i    (rd_q[IW-1:0]),
    .rd_pc_o     (head_pc),
    .rd_instr_o  (head_instr),
    .rd_filled_o (head_filled)
  );

`ifndef SYNTHESIS
  a_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rvalid && (pend == '0)));
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-built flush/reset sequences and
// randomized traffic against a queue-level reference model with an in-order memory.
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus();
  fetch_queue #(.DEPTH(QD), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {logic [31:0] pc; logic [31:0] instr; bit filled;} ent_t;
  typedef struct {int due; logic [31:0] addr;} mreq_t;
  typedef struct {
    bit rs; logic [31:0] pc; bit fl, rdy, mrdy;
    bit e_stall, e_req, e_valid; logic [31:0] e_pc;
  } vec_t;

  ent_t  mdl[$];
  mreq_t mq[$];
  int    disc = 0;
  int    cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
  bit    o_valid, o_stall;
  logic [31:0] o_pc, o_disc;
  vec_t  nv;
  vec_t  tab[$];

  function automatic logic [31:0] idata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: present memory response, check at negedge, advance model, then memory.
  task automatic tick(input bit use_tab, input vec_t v);
    int infl, d;
    bit e_req, e_stall, e_valid, pop, rv, fire, done;
    logic [31:0] rdat, faddr;
    ent_t e;
    mreq_t m;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1; bus.imem_rdata = idata(mq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    end
    @(negedge clk);
    infl = 0;
    foreach (mdl[i]) if (!mdl[i].filled) infl++;
    e_req   = (mdl.size() < QD) && (disc + infl < QD) && !bus.flush;
    e_stall = !((e_req && bus.imem_ready) || bus.flush);
    e_valid = (mdl.size() > 0) && mdl[0].filled;
    chk("imem_req",  32'(bus.imem_req), 32'(e_req));
    chk("imem_addr", bus.imem_addr, bus.pc_in);
    chk("stall_pc",  32'(bus.stall_pc), 32'(e_stall));
    chk("id_valid",  32'(bus.id_valid), 32'(e_valid));
    if (e_valid) begin
      chk("id_pc",    bus.id_pc, mdl[0].pc);
      chk("id_instr", bus.id_instr, mdl[0].instr);
    end else begin
      chk("id_instr_nop", bus.id_instr, NOP_INSTR);
    end
    chk("discard_cnt", 32'(dut.discard_q), 32'(disc));
    if (use_tab) begin
      chk("tab_stall_pc", 32'(bus.stall_pc), 32'(v.e_stall));
      chk("tab_imem_req", 32'(bus.imem_req), 32'(v.e_req));
      chk("tab_id_valid", 32'(bus.id_valid), 32'(v.e_valid));
      if (v.e_valid) chk("tab_id_pc", bus.id_pc, v.e_pc);
    end
    o_valid = bus.id_valid; o_stall = bus.stall_pc; o_pc = bus.id_pc;
    o_disc  = 32'(dut.discard_q);
    rv = bus.imem_rvalid; rdat = bus.imem_rdata;
    fire = bus.imem_req && bus.imem_ready; faddr = bus.imem_addr;
    pop = e_valid && bus.id_ready && !bus.flush;
    if (bus.flush) begin
      disc = disc + infl - (rv ? 1 : 0);
      mdl.delete();
    end else begin
      if (rv) begin
        if (disc > 0) disc--;
        else begin
          done = 1'b0;
          for (int i = 0; i < mdl.size(); i++)
            if (!done && !mdl[i].filled) begin
              mdl[i].instr = rdat; mdl[i].filled = 1'b1; done = 1'b1;
            end
        end
      end
      if (pop) void'(mdl.pop_front());
      if (e_req && bus.imem_ready) begin
        e.pc = bus.pc_in; e.instr = '0; e.filled = 1'b0;
        mdl.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (rv) void'(mq.pop_front());
    if (fire) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.due = d; m.addr = faddr;
      mq.push_back(m);
    end
    cyc++;
  endtask

  // Asserts reset mid-cycle; memory and model restart with the design.
  task automatic do_reset(input bit check_now);
    #2;
    rst = 1'b0;
    bus.flush = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_ready = 1'b0; bus.id_ready = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_stall_pc", 32'(bus.stall_pc), 32'd1);
    end
    mdl.delete(); mq.delete(); disc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    last_due = cyc;
  endtask

  task automatic wait_head(input logic [31:0] want, input int budget, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick(1'b0, nv);
      if (o_valid) got = 1'b1;
    end
    chk({nm, "_seen"}, 32'(o_valid), 32'd1);
    if (got) chk(nm, o_pc, want);
  endtask

  task automatic drive(input logic [31:0] pc, input bit fl, input bit rdy, input bit mrdy);
    bus.pc_in = pc; bus.flush = fl; bus.id_ready = rdy; bus.imem_ready = mrdy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rs, pc, flush, id_ready, imem_ready | stall, req, valid, id_pc
    tab.push_back('{1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00});
    tab.push_back('{1'b0, 32'h0C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04});
    tab.push_back('{1'b0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08});
    tab.push_back('{1'b0, 32'h14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0C});
    tab.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10});
    tab.push_back('{1'b0, 32'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14});
    tab.push_back('{1'b0, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h18});
    tab.push_back('{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    tab.push_back('{1'b0, 32'h28, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20});

    bus.pc_in = '0; bus.flush = 1'b0; bus.id_ready = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    do_reset(1'b1);

    lat_lo = 1; lat_hi = 1;
    foreach (tab[k]) begin
      if (tab[k].rs) do_reset(1'b0);
      drive(tab[k].pc, tab[k].fl, tab[k].rdy, tab[k].mrdy);
      tick(1'b1, tab[k]);
    end

    // Reset with three slots allocated, then fetch resumes from the current pc_in.
    lat_lo = 3; lat_hi = 3;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(32'h80 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      tick(1'b0, nv);
    end
    do_reset(1'b1);
    drive(32'h200, 1'b0, 1'b1, 1'b1);
    wait_head(32'h200, 12, "post_reset_head");

    // Flush with one filled slot and two requests in flight.
    do_reset(1'b0);
    drive(32'h3C, 1'b0, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h40, 1'b0, 1'b0, 1'b0); tick(1'b0, nv);
    drive(32'h40, 1'b0, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h44, 1'b0, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h48, 1'b1, 1'b0, 1'b1); tick(1'b0, nv);
    chk("pre_flush_head", o_pc, 32'h3C);
    drive(32'h100, 1'b0, 1'b1, 1'b1); tick(1'b0, nv);
    chk("flush_id_valid", 32'(o_valid), 32'd0);
    chk("flush_discard", o_disc, 32'd2);
    wait_head(32'h100, 12, "redirect_head");

    // Flush coincident with a response, then a second flush the next cycle.
    lat_lo = 2; lat_hi = 2;
    do_reset(1'b0);
    drive(32'h300, 1'b0, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h304, 1'b0, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h308, 1'b1, 1'b0, 1'b1); tick(1'b0, nv);
    drive(32'h308, 1'b1, 1'b1, 1'b1); tick(1'b0, nv);
    chk("dbl_flush_discard1", o_disc, 32'd1);
    drive(32'h400, 1'b0, 1'b1, 1'b1); tick(1'b0, nv);
    chk("dbl_flush_discard0", o_disc, 32'd0);
    wait_head(32'h400, 12, "dbl_flush_head");

    // Random traffic with a pc register that follows stall_pc and redirects.
    lat_lo = 1; lat_hi = 4;
    do_reset(1'b0);
    bus.pc_in = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset(1'b1);
        bus.pc_in = 32'h2000;
      end
      bus.flush      = ($urandom_range(99) < 5);
      bus.id_ready   = ($urandom_range(99) < 70);
      bus.imem_ready = ($urandom_range(99) < 75);
      tick(1'b0, nv);
      if (bus.flush)    bus.pc_in = $urandom & 32'h0000_FFFC;
      else if (!o_stall) bus.pc_in = bus.pc_in + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
